// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   load_funct3_e : load-type encodings carried in funct3
//   SRC_*         : writeback result-source indices into the flattened source bus
package wb_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } load_funct3_e;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_MEM = 1;
    localparam int unsigned SRC_PC4 = 2;
    localparam int unsigned SRC_IMM = 3;

endpackage

// File: rtl/wb_stage_reg_load_extend.sv
// Load data alignment and sign/zero extension (combinational).
//   i_word   : raw memory readout word
//   i_offset : byte offset within the word
//   i_funct3 : load type
//   o_value  : aligned, extended load result
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  i_word,
    input  logic [OFF_W-1:0] i_offset,
    input  logic [2:0]       i_funct3,
    output logic [XLEN-1:0]  o_value
);

    // Halfword and word accesses ignore the low offset bits below their size.
    logic [OFF_W-1:0] hoff;
    logic [OFF_W-1:0] woff;
    logic [XLEN-1:0]  sb;
    logic [XLEN-1:0]  sh;
    logic [XLEN-1:0]  sw;

    always_comb begin
        hoff = i_offset & ~OFF_W'(1);
        woff = i_offset & ~OFF_W'(3);
        sb   = i_word >> {i_offset, 3'b000};
        sh   = i_word >> {hoff, 3'b000};
        sw   = i_word >> {woff, 3'b000};
        o_value = i_word;
        case (load_funct3_e'(i_funct3))
            LB:      o_value = XLEN'($signed(sb[7:0]));
            LBU:     o_value = XLEN'(sb[7:0]);
            LH:      o_value = XLEN'($signed(sh[15:0]));
            LHU:     o_value = XLEN'(sh[15:0]);
            // On a 32-bit datapath woff is always 0, so LW degenerates to pass-through.
            LW:      o_value = XLEN'($signed(sw[31:0]));
            LWU:     o_value = XLEN'(sw[31:0]);
            default: o_value = i_word;
        endcase
    end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with writeback result selection.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_stall/i_flush : hold the slot / insert a bubble (flush wins)
//   i_valid         : memory-stage instruction valid
//   i_src_data      : NUM_SRC flattened result sources, slice k = source k
//   i_result_src    : result source select
//   i_load_funct3   : load type applied to source 1
//   i_rd/i_reg_write: destination register and write request
//   o_wb            : selected writeback/forward value (from registered state)
//   o_rd            : registered destination
//   o_reg_write     : qualified register-file write enable
//   o_valid         : WB-stage valid
//   o_retired       : retired-instruction count (wraps)
module wb_stage_reg
    import wb_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned SEL_W     = $clog2(NUM_SRC),
    localparam int unsigned OFF_W     = $clog2(XLEN / 8)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_valid,
    input  logic [NUM_SRC*XLEN-1:0] i_src_data,
    input  logic [SEL_W-1:0]        i_result_src,
    input  logic [2:0]              i_load_funct3,
    input  logic [REG_ADDR_W-1:0]   i_rd,
    input  logic                    i_reg_write,
    output logic [XLEN-1:0]         o_wb,
    output logic [REG_ADDR_W-1:0]   o_rd,
    output logic                    o_reg_write,
    output logic                    o_valid,
    output logic [CNT_W-1:0]        o_retired
);

    logic [NUM_SRC-1:0][XLEN-1:0] src_q;
    logic [SEL_W-1:0]             sel_q;
    logic [2:0]                   funct3_q;
    logic [OFF_W-1:0]             off_q;
    logic [REG_ADDR_W-1:0]        rd_q;
    logic                         reg_write_q;
    logic                         valid_q;
    logic [CNT_W-1:0]             retired_q;
    logic [XLEN-1:0]              load_val;
    logic [XLEN-1:0]              wb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            src_q       <= '0;
            sel_q       <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
            retired_q   <= '0;
        end else begin
            // The WB instruction leaves the slot whenever it is not held;
            // a flush empties the slot even under stall, so it retires too.
            if (valid_q && (!i_stall || i_flush)) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (i_flush) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
            end else if (!i_stall) begin
                src_q       <= i_src_data;
                sel_q       <= i_result_src;
                funct3_q    <= i_load_funct3;
                off_q       <= i_src_data[OFF_W-1:0];
                rd_q        <= i_rd;
                reg_write_q <= i_reg_write;
                valid_q     <= i_valid;
            end
        end
    end

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .i_word   (src_q[SRC_MEM]),
        .i_offset (off_q),
        .i_funct3 (funct3_q),
        .o_value  (load_val)
    );

    // Out-of-range selects fall through to zero.
    always_comb begin
        wb = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (sel_q == SEL_W'(k)) begin
                wb = (k == SRC_MEM) ? load_val : src_q[k];
            end
        end
    end

    assign o_wb        = wb;
    assign o_rd        = rd_q;
    assign o_reg_write = reg_write_q & valid_q & (rd_q != '0);
    assign o_valid     = valid_q;
    assign o_retired   = retired_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
module tb_wb_stage_reg;
    import wb_pkg::*;

    typedef struct {
        logic [31:0] wb;
        logic        rw;
        logic        v;
        logic [4:0]  rd;
        logic [31:0] ret;
    } exp_t;

    logic clk, rst_n, stall, flush, valid, rw;
    logic [2:0] f3;
    logic [4:0] rd;

    // main instance: defaults
    logic [127:0] src_a;
    logic [1:0]   sel_a;
    logic [31:0]  wb_a, ret_a;
    logic [4:0]   rd_a;
    logic         rw_a, v_a;

    // NUM_SRC=3, CNT_W=4
    logic [95:0]  src_b;
    logic [1:0]   sel_b;
    logic [31:0]  wb_b;
    logic [4:0]   rd_b;
    logic         rw_b, v_b;
    logic [3:0]   ret_b;

    // XLEN=64, NUM_SRC=2
    logic [127:0] src_c;
    logic [0:0]   sel_c;
    logic [63:0]  wb_c;
    logic [4:0]   rd_c;
    logic         rw_c, v_c;
    logic [31:0]  ret_c;

    int tests = 0;
    int fails = 0;

    exp_t sb[$];
    logic        m_valid, m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_wb, m_ret;

    wb_stage_reg dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_src_data(src_a), .i_result_src(sel_a), .i_load_funct3(f3), .i_rd(rd),
        .i_reg_write(rw), .o_wb(wb_a), .o_rd(rd_a), .o_reg_write(rw_a), .o_valid(v_a),
        .o_retired(ret_a)
    );

    wb_stage_reg #(.XLEN(32), .NUM_SRC(3), .REG_ADDR_W(5), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_src_data(src_b), .i_result_src(sel_b), .i_load_funct3(f3), .i_rd(rd),
        .i_reg_write(rw), .o_wb(wb_b), .o_rd(rd_b), .o_reg_write(rw_b), .o_valid(v_b),
        .o_retired(ret_b)
    );

    wb_stage_reg #(.XLEN(64), .NUM_SRC(2), .REG_ADDR_W(5), .CNT_W(32)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_src_data(src_c), .i_result_src(sel_c), .i_load_funct3(f3), .i_rd(rd),
        .i_reg_write(rw), .o_wb(wb_c), .o_rd(rd_c), .o_reg_write(rw_c), .o_valid(v_c),
        .o_retired(ret_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'($urandom); rw = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
        rd = 5'($urandom); f3 = 3'($urandom);
        sel_a = 2'($urandom); sel_b = 2'($urandom); sel_c = 1'($urandom);
        src_a = {$urandom, $urandom, $urandom, $urandom};
        src_b = {$urandom, $urandom, $urandom};
        src_c = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_wb = '0; m_ret = '0;
        sb.delete();
    endtask

    // Drives one cycle of stimulus and pushes the expected main-instance state.
    task automatic step(input logic iv, input logic irw, input logic ist, input logic ifl,
                        input logic [4:0] ird, input logic [2:0] if3, input logic [1:0] isel,
                        input logic [127:0] isrc, input logic [31:0] ewb);
        exp_t e;
        valid = iv; rw = irw; stall = ist; flush = ifl; rd = ird; f3 = if3;
        sel_a = isel; src_a = isrc;
        @(posedge clk);
        if (m_valid && (!ist || ifl)) m_ret = m_ret + 1;
        if (ifl) begin
            m_valid = 1'b0; m_rw = 1'b0;
        end else if (!ist) begin
            m_valid = iv; m_rw = irw; m_rd = ird; m_wb = ewb;
        end
        e.wb = m_wb; e.v = m_valid; e.rd = m_rd; e.ret = m_ret;
        e.rw = m_valid && m_rw && (m_rd != 5'd0);
        sb.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests++;
        if ({wb_a, rd_a, rw_a, v_a, ret_a} !== '0) begin
            fails++;
            $display("FAIL reset_a got wb=%h rd=%0d rw=%b v=%b ret=%0d want all 0", wb_a, rd_a, rw_a, v_a, ret_a);
        end
        tests++;
        if ({wb_b, ret_b, v_b} !== '0) begin
            fails++;
            $display("FAIL reset_b got wb=%h ret=%0d v=%b want 0", wb_b, ret_b, v_b);
        end
        tests++;
        if ({wb_c, ret_c, v_c, rw_c} !== '0) begin
            fails++;
            $display("FAIL reset_c got wb=%h ret=%0d v=%b want 0", wb_c, ret_c, v_c);
        end
        // mid-cycle asynchronous reset
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, LW, 2'd0, {96'h0, 32'h5A5A5A5A}, 32'h5A5A5A5A);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, LW, 2'd0, {96'h0, 32'h5A5A5A5A}, 32'h5A5A5A5A);
        tests++;
        if (v_a !== 1'b1 || wb_a !== 32'h5A5A5A5A || ret_a !== 32'd1) begin
            fails++;
            $display("FAIL pre_async got v=%b wb=%h ret=%0d want 1 5a5a5a5a 1", v_a, wb_a, ret_a);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({wb_a, rd_a, rw_a, v_a, ret_a} !== '0) begin
            fails++;
            $display("FAIL async_reset got wb=%h rd=%0d rw=%b v=%b ret=%0d want all 0", wb_a, rd_a, rw_a, v_a, ret_a);
        end
        apply_reset();
    endtask

    task automatic test_select();
        logic [127:0] s;
        logic [1:0]   sels [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
        logic [4:0]   rds  [4] = '{5'd5, 5'd5, 5'd5, 5'd0};
        logic [31:0]  exps [4] = '{32'h11111111, 32'h00000104, 32'hFFFFF000, 32'h11111111};
        exp_t e;
        s = {32'hFFFFF000, 32'h00000104, 32'hDEADBEEF, 32'h11111111};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1'b1, 1'b1, 1'b0, 1'b0, rds[i], LW, sels[i], s, exps[i]);
            else       step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, LW, 2'd0, s, 32'h0);
            e = sb.pop_front();
            tests++;
            if (v_a !== e.v) begin fails++; $display("FAIL sel_valid[%0d] got %b want %b", i, v_a, e.v); end
            tests++;
            if (rw_a !== e.rw) begin fails++; $display("FAIL sel_regwrite[%0d] got %b want %b", i, rw_a, e.rw); end
            tests++;
            if (ret_a !== e.ret) begin fails++; $display("FAIL sel_retired[%0d] got %0d want %0d", i, ret_a, e.ret); end
            if (e.v) begin
                tests++;
                if (wb_a !== e.wb) begin fails++; $display("FAIL sel_wb[%0d] got %h want %h", i, wb_a, e.wb); end
                tests++;
                if (rd_a !== e.rd) begin fails++; $display("FAIL sel_rd[%0d] got %0d want %0d", i, rd_a, e.rd); end
            end
        end
    endtask

    task automatic test_load();
        logic [1:0]  offs [11] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd2, 2'd1};
        logic [2:0]  f3s  [11] = '{LB, LBU, LH, LHU, LW, LB, LBU, LH, LHU, LD, 3'b111};
        logic [31:0] exps [11] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFF8899, 32'h00008899,
                                   32'h8899AABB, 32'hFFFFFFBB, 32'h000000AA, 32'hFFFF8899,
                                   32'h0000AABB, 32'h8899AABB, 32'h8899AABB};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 5'd12, f3s[i], 2'd1,
                 {32'h0, 32'h0, 32'h8899AABB, 30'h0, offs[i]}, exps[i]);
            e = sb.pop_front();
            tests++;
            if (wb_a !== e.wb) begin fails++; $display("FAIL load[%0d] f3=%0d off=%0d got %h want %h", i, f3s[i], offs[i], wb_a, e.wb); end
            tests++;
            if (rw_a !== e.rw) begin fails++; $display("FAIL load_regwrite[%0d] got %b want %b", i, rw_a, e.rw); end
        end
    endtask

    task automatic test_stall_flush();
        logic [127:0] a, b;
        exp_t e;
        a = {96'h0, 32'hAAAA0001};
        b = {96'h0, 32'hBBBB0002};
        apply_reset();
        // A captured, then held 3 cycles while B is presented, then stall+flush, then B
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       step(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, LW, 2'd0, a, 32'hAAAA0001);
                1, 2, 3: step(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, LW, 2'd0, b, 32'hBBBB0002);
                4:       step(1'b1, 1'b1, 1'b1, 1'b1, 5'd8, LW, 2'd0, b, 32'hBBBB0002);
                default: step(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, LW, 2'd0, b, 32'hBBBB0002);
            endcase
            e = sb.pop_front();
            tests++;
            if (v_a !== e.v) begin fails++; $display("FAIL sf_valid[%0d] got %b want %b", i, v_a, e.v); end
            tests++;
            if (rw_a !== e.rw) begin fails++; $display("FAIL sf_regwrite[%0d] got %b want %b", i, rw_a, e.rw); end
            tests++;
            if (ret_a !== e.ret) begin fails++; $display("FAIL sf_retired[%0d] got %0d want %0d", i, ret_a, e.ret); end
            if (e.v) begin
                tests++;
                if (wb_a !== e.wb) begin fails++; $display("FAIL sf_wb[%0d] got %h want %h", i, wb_a, e.wb); end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, LW, 2'd0, b, 32'h0);
        e = sb.pop_front();
        tests++;
        if (ret_a !== e.ret) begin fails++; $display("FAIL sf_final_retired got %0d want %0d", ret_a, e.ret); end
    endtask

    task automatic test_wrap_and_range();
        apply_reset();
        src_b = {32'hCCCC0002, 32'h0, 32'h0};
        sel_b = 2'd2;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, LW, 2'd0, '0, 32'h0);
            if (i == 0) begin
                tests++;
                if (wb_b !== 32'hCCCC0002) begin fails++; $display("FAIL n3_sel2 got %h want cccc0002", wb_b); end
            end
            if (i == 15) begin
                tests++;
                if (ret_b !== 4'd15) begin fails++; $display("FAIL cnt_15 got %0d want 15", ret_b); end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, LW, 2'd0, '0, 32'h0);
        tests++;
        if (ret_b !== 4'd1) begin fails++; $display("FAIL cnt_wrap got %0d want 1", ret_b); end
        sel_b = 2'd3;
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, LW, 2'd0, '0, 32'h0);
        tests++;
        if (wb_b !== 32'h0) begin fails++; $display("FAIL n3_sel3 got %h want 0", wb_b); end
        sb.delete();
    endtask

    task automatic test_xlen64();
        logic [63:0] mem  [4] = '{64'h00000000_80000000, 64'h00000000_80000000,
                                  64'h12345678_00000000, 64'h12345678_9ABCDEF0};
        logic [2:0]  offs [4] = '{3'd0, 3'd0, 3'd4, 3'd4};
        logic [2:0]  f3s  [4] = '{LWU, LW, LWU, LD};
        logic [63:0] exps [4] = '{64'h00000000_80000000, 64'hFFFFFFFF_80000000,
                                  64'h00000000_12345678, 64'h12345678_9ABCDEF0};
        apply_reset();
        sel_c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_c = {mem[i], 61'h0, offs[i]};
            step(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, f3s[i], 2'd0, '0, 32'h0);
            tests++;
            if (wb_c !== exps[i]) begin fails++; $display("FAIL x64_load[%0d] got %h want %h", i, wb_c, exps[i]); end
        end
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b0; rw = 1'b0;
        f3 = '0; rd = '0; src_a = '0; sel_a = '0; src_b = '0; sel_b = '0; src_c = '0; sel_c = '0;
        m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_wb = '0; m_ret = '0;
        test_reset();
        test_select();
        test_load();
        test_stall_flush();
        test_wrap_and_range();
        test_xlen64();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
